// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared types and defaults for the UART transmit FIFO slice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int UART_FIFO_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        DRAIN  = 2'd2
    } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_fifo_mem.sv
// ============================================================================
// Module   : uart_fifo_mem
// Brief    : DEPTH x 8 register array, one write port, one async read port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_fifo_mem #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [7:0]        i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [7:0]        o_rdata
);

    logic [7:0] r_mem [DEPTH];

    // Storage carries no reset; occupancy is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
// Module   : uart_tx_fifo
// Brief    : Byte FIFO and launch sequencer feeding the RS-232 transmitter.
//            Define UART_TX_FIFO_OVF_EN to enable the sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = UART_FIFO_DEPTH,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        wrData,
    input  logic              wrEn,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic [7:0]        txByte,
    output logic              txStart,
    input  logic              txBusy,
    output logic              ovf,
    input  logic              ovfClr
);

    localparam logic [ADDR_W:0] c_full_cnt = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic [7:0]        r_tx_byte;
    logic              r_tx_start;
    logic [7:0]        w_rd_data;
    logic              w_push;
    logic              w_pop;
    logic              w_load;
    tx_state_t         r_state;
    tx_state_t         w_state_nxt;

    assign full    = (r_count == c_full_cnt);
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign txByte  = r_tx_byte;
    assign txStart = r_tx_start;

    // The byte in flight stays counted until the transmitter acknowledges it.
    assign w_push = wrEn && !full;
    assign w_pop  = (r_state == LAUNCH) && txBusy;
    assign w_load = (r_state == IDLE) && (w_state_nxt == LAUNCH);

    uart_fifo_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (wrData),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_tx_start <= 1'b0;
            r_tx_byte  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_tx_start <= (w_state_nxt == LAUNCH);
            if (w_load) r_tx_byte <= w_rd_data;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (!empty && !txBusy) w_state_nxt = LAUNCH;
            LAUNCH:  if (txBusy)            w_state_nxt = DRAIN;
            DRAIN:   if (!txBusy)           w_state_nxt = IDLE;
            default:                        w_state_nxt = IDLE;
        endcase
    end

`ifdef UART_TX_FIFO_OVF_EN
    logic r_ovf;

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (wrEn && full) begin
            r_ovf <= 1'b1;
        end else if (ovfClr) begin
            r_ovf <= 1'b0;
        end
    end

    assign ovf = r_ovf;
`else
    logic w_unused_ovf_clr;

    assign w_unused_ovf_clr = ovfClr;
    assign ovf              = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// ============================================================================
// Module   : tb_uart_tx_fifo
// Brief    : Randomised bench for uart_tx_fifo with a queue-based reference.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_fifo;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        wrData;
    logic              wrEn;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic [7:0]        txByte;
    logic              txStart;
    logic              txBusy;
    logic              ovf;
    logic              ovfClr;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] q[$];
    logic       m_ovf;
    int         emitted;
    bit         tx_auto;
    int         wait_left;
    int         len_left;
    int         mark;

    uart_tx_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wrData  (wrData),
        .wrEn    (wrEn),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .txByte  (txByte),
        .txStart (txStart),
        .txBusy  (txBusy),
        .ovf     (ovf),
        .ovfClr  (ovfClr)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Transmitter stand-in: raises busy a random delay after txStart, holds it a random frame length.
    task automatic tx_drive();
        if (!tx_auto) return;
        if (txBusy) begin
            if (len_left == 0) txBusy = 1'b0;
            else               len_left--;
        end else if (txStart) begin
            if (wait_left == 0) begin
                txBusy    = 1'b1;
                len_left  = $urandom_range(0, 4);
                wait_left = $urandom_range(0, 3);
            end else begin
                wait_left--;
            end
        end
    endtask

    task automatic set_auto();
        tx_auto   = 1'b1;
        len_left  = 1;
        wait_left = $urandom_range(0, 3);
    endtask

    task automatic cycle(input logic we, input logic [7:0] d, input logic clr);
        logic       start_pre;
        logic       busy_pre;
        logic [7:0] byte_pre;
        bit         room;
        wrEn   = we;
        wrData = d;
        ovfClr = clr;
        tx_drive();
        start_pre = txStart;
        busy_pre  = txBusy;
        byte_pre  = txByte;
        @(posedge clk);
        room = (q.size() < DEPTH);
        if (start_pre && busy_pre) begin
            check_eq("ack_has_byte", q.size() > 0, 1);
            if (q.size() > 0) begin
                check_eq("emit_byte", byte_pre, q[0]);
                void'(q.pop_front());
                emitted++;
            end
        end
        if (we && room) q.push_back(d);
`ifdef UART_TX_FIFO_OVF_EN
        if (we && !room) m_ovf = 1'b1;
        else if (clr)    m_ovf = 1'b0;
`endif
        #1;
        check_eq("count", count, q.size());
        check_eq("empty", empty, q.size() == 0);
        check_eq("full", full, q.size() == DEPTH);
        check_eq("ovf", ovf, m_ovf);
        check_eq("start_with_no_data", txStart && (q.size() == 0), 0);
        wrEn   = 1'b0;
        ovfClr = 1'b0;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        wrEn    = 1'b0;
        wrData  = '0;
        ovfClr  = 1'b0;
        txBusy  = 1'b0;
        tx_auto = 1'b0;
        q.delete();
        m_ovf   = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 600 && (q.size() > 0 || txBusy || txStart); i++) begin
            cycle(1'b0, 8'h00, 1'b0);
        end
        check_eq("drain_done", q.size(), 0);
        check_eq("drain_empty", empty, 1);
    endtask

    initial begin
        emitted = 0;
        do_reset();
        check_eq("rst_count", count, 0);
        check_eq("rst_empty", empty, 1);
        check_eq("rst_full", full, 0);
        check_eq("rst_start", txStart, 0);
        check_eq("rst_byte", txByte, 0);
        check_eq("rst_ovf", ovf, 0);

        // Single byte, transmitter acknowledges three cycles into the launch.
        cycle(1'b1, 8'h55, 1'b0);
        check_eq("t1_start_lat0", txStart, 0);
        cycle(1'b0, 8'h00, 1'b0);
        check_eq("t1_start", txStart, 1);
        check_eq("t1_byte", txByte, 8'h55);
        repeat (2) cycle(1'b0, 8'h00, 1'b0);
        check_eq("t1_start_held", txStart, 1);
        check_eq("t1_count_held", count, 1);
        txBusy = 1'b1;
        cycle(1'b0, 8'h00, 1'b0);
        check_eq("t1_start_drop", txStart, 0);
        check_eq("t1_count_pop", count, 0);
        txBusy = 1'b0;
        repeat (2) cycle(1'b0, 8'h00, 1'b0);

        // Fill to full, then overflow, then drain in order.
        mark = emitted;
        for (int i = 1; i <= 16; i++) cycle(1'b1, 8'(i), 1'b0);
        check_eq("t2_full", full, 1);
        check_eq("t2_count", count, 16);
        cycle(1'b1, 8'hEE, 1'b0);
        check_eq("t3_count", count, 16);
`ifdef UART_TX_FIFO_OVF_EN
        check_eq("t3_ovf", ovf, 1);
`else
        check_eq("t3_ovf", ovf, 0);
`endif
        cycle(1'b0, 8'h00, 1'b1);
        check_eq("t3_ovf_clr", ovf, 0);
        set_auto();
        drain();
        check_eq("t2_emitted", emitted - mark, 16);

        // Simultaneous write and pop at count 5.
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'h20 + 8'(i), 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        check_eq("t4_launch", txStart, 1);
        txBusy = 1'b1;
        cycle(1'b1, 8'h25, 1'b0);
        check_eq("t4_count", count, 5);
        mark = emitted;
        set_auto();
        drain();
        check_eq("t4_emitted", emitted - mark, 5);

        // Asynchronous reset during LAUNCH with bytes queued.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'h70 + 8'(i), 1'b0);
        check_eq("t5_launch", txStart, 1);
        #2 rst = 1'b1;
        #1;
        check_eq("t5_start", txStart, 0);
        check_eq("t5_count", count, 0);
        check_eq("t5_empty", empty, 1);
        q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        mark = emitted;
        set_auto();
        repeat (10) cycle(1'b0, 8'h00, 1'b0);
        check_eq("t5_no_emit", emitted - mark, 0);
        check_eq("t5_quiet", txStart, 0);

        // Foreign frame in progress blocks the launch.
        do_reset();
        txBusy = 1'b1;
        cycle(1'b1, 8'hA3, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 8'h00, 1'b0);
            check_eq("t6_blocked", txStart, 0);
        end
        txBusy = 1'b0;
        cycle(1'b0, 8'h00, 1'b0);
        check_eq("t6_start", txStart, 1);
        check_eq("t6_byte", txByte, 8'hA3);
        set_auto();
        drain();

        // Random traffic against the queue model.
        do_reset();
        set_auto();
        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 99) < 45, 8'($urandom), $urandom_range(0, 19) == 0);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
